// File: rtl/uart_send_pkg.sv
// Shared definitions for the multi-source UART sender.
//   - FSM state encoding (IDLE / WAIT_HI / WAIT_LO) as plain localparams
//   - width helpers: src_w() for source index width, cnt_w() for occupancy width
//   - tx_entry_t: FIFO entry layout {src, data} at the default widths
//     (NUM_SRC <= 8, DATA_W = 8); the top rebuilds the same layout at its
//     own parameter widths.
package uart_send_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT_HI = 2'd1;
    localparam state_t ST_WAIT_LO = 2'd2;

    // Source index width; a single source still needs one bit.
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
    } tx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request / data (ignored when full without a pop)
//   pop, rdata    read request / head-of-queue data (show-ahead)
//   full, empty   status flags
//   count         current occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import uart_send_pkg::*;
#(
    parameter  int WIDTH = 11,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_multi_src_sender.sv
// Multi-source UART byte sender.
// Each of NUM_SRC producers has a one-entry holding register; a round-robin
// arbiter moves pending bytes into a shared TX FIFO, and a handshake FSM
// issues one tx_start pulse per byte to the uart, pacing on tx_busy.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src_valid/src_data  per-source request strobe / byte (source i at [i*DATA_W +: DATA_W])
//   src_drop            sticky per-source "request lost" flags; clear_drop clears them
//   tx_data/tx_start    byte and one-cycle send pulse to the uart; tx_busy from uart
//   fifo_count          TX FIFO occupancy
//   last_sent/last_src  last byte issued and its source, for the display
// Optional: define UART_SEND_TIMEOUT_EN to add the TIMEOUT_CYC parameter and a
// sticky tx_timeout output; WAIT_HI then gives up after TIMEOUT_CYC cycles.
module uart_multi_src_sender
    import uart_send_pkg::*;
#(
    parameter  int NUM_SRC     = 2,
    parameter  int DATA_W      = 8,
    parameter  int FIFO_DEPTH  = 16,
`ifdef UART_SEND_TIMEOUT_EN
    parameter  int TIMEOUT_CYC = 1024,
`endif
    localparam int SRC_W       = src_w(NUM_SRC),
    localparam int CW          = cnt_w(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_drop,
    input  logic                      clear_drop,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [CW-1:0]             fifo_count,
    output logic [DATA_W-1:0]         last_sent,
    output logic [SRC_W-1:0]          last_src
`ifdef UART_SEND_TIMEOUT_EN
    ,
    output logic                      tx_timeout
`endif
);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [NUM_SRC-1:0]             pend_q, pend_d;
    logic [NUM_SRC-1:0][DATA_W-1:0] pend_data_q, pend_data_d;
    logic [NUM_SRC-1:0]             src_drop_q, src_drop_d;
    logic [SRC_W-1:0]               last_gnt_q, last_gnt_d;
    state_t                         state_q, state_d;
    logic                           tx_start_q, tx_start_d;
    logic [DATA_W-1:0]              tx_data_q, tx_data_d;
    logic [SRC_W-1:0]               last_src_q, last_src_d;

    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;
    logic             pop;
    logic             fifo_full, fifo_empty;
    entry_t           wr_entry, rd_entry;
    int               idx;

    sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt_vld),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Round-robin: scan starts one past the last granted source.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_gnt_q) + k) % NUM_SRC;
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(idx);
            end
        end
        // A full FIFO still accepts when the FSM pops this cycle.
        if (fifo_full && !pop) begin
            gnt_vld = 1'b0;
        end
        wr_entry.src  = gnt_idx;
        wr_entry.data = pend_data_q[gnt_idx];
        last_gnt_d    = gnt_vld ? gnt_idx : last_gnt_q;
    end

    // Holding registers: a source being granted this cycle can reload at once.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        src_drop_d  = clear_drop ? '0 : src_drop_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_vld && (int'(gnt_idx) == i)) begin
                pend_d[i] = 1'b0;
            end
            if (src_valid[i]) begin
                if (!pend_d[i]) begin
                    pend_d[i]      = 1'b1;
                    pend_data_d[i] = src_data[i*DATA_W +: DATA_W];
                end else begin
                    src_drop_d[i] = 1'b1;   // set beats clear_drop
                end
            end
        end
    end

`ifdef UART_SEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            tx_timeout_q, tx_timeout_d;
    assign tx_timeout = tx_timeout_q;
`endif

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_src_d = last_src_q;
`ifdef UART_SEND_TIMEOUT_EN
        to_cnt_d     = '0;
        tx_timeout_d = clear_drop ? 1'b0 : tx_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = rd_entry.data;
                    last_src_d = rd_entry.src;
                    state_d    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
`ifdef UART_SEND_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                    state_d      = ST_IDLE;
                    tx_timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            pend_data_q  <= '0;
            src_drop_q   <= '0;
            last_gnt_q   <= '0;
            state_q      <= ST_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            last_src_q   <= '0;
`ifdef UART_SEND_TIMEOUT_EN
            to_cnt_q     <= '0;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            src_drop_q   <= src_drop_d;
            last_gnt_q   <= last_gnt_d;
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            last_src_q   <= last_src_d;
`ifdef UART_SEND_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            tx_timeout_q <= tx_timeout_d;
`endif
        end
    end

    assign src_drop  = src_drop_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign last_sent = tx_data_q;   // same register: last byte issued
    assign last_src  = last_src_q;

endmodule

// File: tb/tb_uart_multi_src_sender.sv
// Testbench for uart_multi_src_sender (default parameters, timeout feature off).
module tb_uart_multi_src_sender;

    localparam int NS    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int FRAME = 20;   // uart model busy length in cycles

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear_drop = 1'b0;
    logic              tx_busy = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS*DW-1:0]  src_data = '0;
    logic [NS-1:0]     src_drop;
    logic [DW-1:0]     tx_data, last_sent;
    logic              tx_start;
    logic [4:0]        fifo_count;
    logic [0:0]        last_src;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_multi_src_sender #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_drop   (src_drop),
        .clear_drop (clear_drop),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .last_sent  (last_sent),
        .last_src   (last_src)
    );

    // uart model + pulse monitor. Busy rises the cycle after a start and stays
    // high FRAME cycles. Every observed pulse is logged as src*256+data.
    int  cyc = 0;
    bit  force_busy = 1'b0;
    int  model_rst_req = 0;
    int  obs_q[$];
    int  obs_cyc[$];
    int  busy_overlap = 0;

    initial begin : uart_model
        bit model_busy;
        bit start_seen;
        int busy_left;
        int seen_rst;
        model_busy = 0; start_seen = 0; busy_left = 0; seen_rst = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (seen_rst != model_rst_req) begin
                seen_rst = model_rst_req;
                model_busy = 0; start_seen = 0; busy_left = 0;
            end
            if (tx_start === 1'b1) begin
                obs_q.push_back(int'(last_src) * 256 + int'(tx_data));
                obs_cyc.push_back(cyc);
                if (tx_busy) busy_overlap++;
            end
            if (start_seen) begin
                model_busy = 1; busy_left = FRAME; start_seen = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) model_busy = 0;
            end
            if (tx_start === 1'b1) start_seen = 1;
            tx_busy = force_busy | model_busy;
        end
    end

    task automatic drive(input logic [NS-1:0] v, input logic [NS*DW-1:0] d);
        @(negedge clk);
        src_valid = v;
        src_data  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; src_valid = '0; clear_drop = 1'b0;
        model_rst_req++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (obs_q.size() >= target) begin ok = 1; break; end
            @(negedge clk);
        end
        if (obs_q.size() >= target) ok = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (last_sent !== 8'h00) begin failures++; $display("FAIL reset_last_sent got=%h exp=00", last_sent); end
        checks++; if (last_src !== 1'b0) begin failures++; $display("FAIL reset_last_src got=%b exp=0", last_src); end
        checks++; if (src_drop !== 2'b00) begin failures++; $display("FAIL reset_src_drop got=%b exp=00", src_drop); end
    endtask

    task automatic test_single();
        int base, k, n;
        bit ok;
        do_reset();
        base = obs_q.size();
        drive(2'b10, {8'h41, 8'h00});
        k = cyc + 1;
        drive(2'b00, '0);
        wait_pulses(base + 1, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=no_pulse exp=pulse"); end
        if (ok) begin
            checks++; if (obs_cyc[base] != k + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", obs_cyc[base] - k, 2); end
            checks++; if (obs_q[base] != 256 + 'h41) begin failures++; $display("FAIL single_data got=%h exp=%h", obs_q[base], 256 + 'h41); end
        end
        repeat (FRAME + 10) @(negedge clk);
        n = obs_q.size() - base;
        checks++; if (n != 1) begin failures++; $display("FAIL single_pulse_count got=%0d exp=1", n); end
        checks++; if (tx_data !== 8'h41 || last_src !== 1'b1) begin failures++; $display("FAIL single_hold got=%h/%b exp=41/1", tx_data, last_src); end
        checks++; if (src_drop !== 2'b00) begin failures++; $display("FAIL single_drop got=%b exp=00", src_drop); end
    endtask

    task automatic test_simultaneous();
        int base, ov;
        bit ok;
        do_reset();
        base = obs_q.size();
        ov = busy_overlap;
        drive(2'b11, {8'h22, 8'h11});
        drive(2'b00, '0);
        wait_pulses(base + 2, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL simul_timeout got=%0d exp=2", obs_q.size() - base); end
        if (ok) begin
            checks++; if (obs_q[base] != 256 + 'h22) begin failures++; $display("FAIL simul_first got=%h exp=%h", obs_q[base], 256 + 'h22); end
            checks++; if (obs_q[base+1] != 'h11) begin failures++; $display("FAIL simul_second got=%h exp=11", obs_q[base+1]); end
            checks++; if (obs_cyc[base+1] - obs_cyc[base] < FRAME + 2) begin failures++; $display("FAIL simul_spacing got=%0d exp>=%0d", obs_cyc[base+1] - obs_cyc[base], FRAME + 2); end
        end
        checks++; if (busy_overlap != ov) begin failures++; $display("FAIL simul_start_while_busy got=%0d exp=0", busy_overlap - ov); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] d[17];
        int base, ov, got;
        bit ok;
        force_busy = 1'b1;
        do_reset();
        base = obs_q.size();
        ov = busy_overlap;
        for (int i = 0; i < 17; i++) begin
            d[i] = 8'($urandom);
            drive(2'b01, {8'h00, d[i]});
        end
        drive(2'b00, '0);
        repeat (3) @(negedge clk);
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", fifo_count); end
        checks++; if (src_drop !== 2'b00) begin failures++; $display("FAIL full_no_drop got=%b exp=00", src_drop); end
        drive(2'b01, {8'h00, 8'hEE});
        drive(2'b00, '0);
        checks++; if (src_drop !== 2'b01) begin failures++; $display("FAIL full_drop got=%b exp=01", src_drop); end
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("FAIL full_saturate got=%0d exp=16", fifo_count); end
        @(negedge clk); clear_drop = 1'b1;
        @(negedge clk); clear_drop = 1'b0;
        checks++; if (src_drop !== 2'b00) begin failures++; $display("FAIL clear_drop got=%b exp=00", src_drop); end
        @(negedge clk); clear_drop = 1'b1; src_valid = 2'b01; src_data = {8'h00, 8'hDD};
        @(negedge clk); clear_drop = 1'b0; src_valid = 2'b00;
        checks++; if (src_drop !== 2'b01) begin failures++; $display("FAIL drop_beats_clear got=%b exp=01", src_drop); end
        @(negedge clk); clear_drop = 1'b1;
        @(negedge clk); clear_drop = 1'b0;
        checks++; if (obs_q.size() != base) begin failures++; $display("FAIL full_no_pulse_while_busy got=%0d exp=0", obs_q.size() - base); end
        force_busy = 1'b0;
        wait_pulses(base + 17, 17 * (FRAME + 10), ok);
        got = obs_q.size() - base;
        checks++; if (!ok) begin failures++; $display("FAIL full_drain_timeout got=%0d exp=17", got); end
        if (ok) begin
            for (int i = 0; i < 17; i++) begin
                checks++; if (obs_q[base+i] != int'(d[i])) begin failures++; $display("FAIL full_drain_order idx=%0d got=%h exp=%h", i, obs_q[base+i], d[i]); end
            end
        end
        repeat (FRAME + 5) @(negedge clk);
        checks++; if (fifo_count !== 5'd0 || obs_q.size() != base + 17) begin failures++; $display("FAIL full_drain_end got=%0d/%0d exp=0/17", fifo_count, obs_q.size() - base); end
        checks++; if (busy_overlap != ov) begin failures++; $display("FAIL full_start_while_busy got=%0d exp=0", busy_overlap - ov); end
    endtask

    task automatic test_random(input int nreq);
        int exp_q[$];
        int base, ov, s;
        logic [7:0] b;
        logic [NS*DW-1:0] dv;
        logic [NS-1:0] vv;
        bit ok;
        do_reset();
        base = obs_q.size();
        ov = busy_overlap;
        for (int n = 0; n < nreq; n++) begin
            repeat ($urandom_range(0, 3)) drive(2'b00, '0);
            s  = int'($urandom_range(0, NS - 1));
            b  = 8'($urandom);
            vv = '0; vv[s] = 1'b1;
            dv = $urandom;
            dv[s*DW +: DW] = b;
            drive(vv, dv);
            exp_q.push_back(s * 256 + int'(b));
        end
        drive(2'b00, '0);
        wait_pulses(base + nreq, nreq * (FRAME + 10) + 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_timeout got=%0d exp=%0d", obs_q.size() - base, nreq); end
        if (ok) begin
            for (int i = 0; i < nreq; i++) begin
                checks++; if (obs_q[base+i] != exp_q[i]) begin failures++; $display("FAIL rand_order idx=%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
                if (i > 0) begin
                    checks++; if (obs_cyc[base+i] - obs_cyc[base+i-1] < FRAME + 2) begin failures++; $display("FAIL rand_spacing idx=%0d got=%0d exp>=%0d", i, obs_cyc[base+i] - obs_cyc[base+i-1], FRAME + 2); end
                end
            end
        end
        checks++; if (src_drop !== 2'b00) begin failures++; $display("FAIL rand_drop got=%b exp=00", src_drop); end
        checks++; if (busy_overlap != ov) begin failures++; $display("FAIL rand_start_while_busy got=%0d exp=0", busy_overlap - ov); end
        repeat (FRAME + 5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base, n;
        bit ok;
        do_reset();
        base = obs_q.size();
        for (int i = 0; i < 6; i++) drive(2'b01, {8'h00, 8'(8'h60 + i)});
        drive(2'b00, '0);
        wait_pulses(base + 1, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_first_pulse got=none exp=pulse"); end
        repeat (FRAME / 2) @(negedge clk);
        checks++; if (fifo_count !== 5'd5) begin failures++; $display("FAIL rstmid_queued got=%0d exp=5", fifo_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_tx_start got=%b exp=0", tx_start); end
        n = obs_q.size();
        repeat (FRAME * 3) @(negedge clk);
        checks++; if (obs_q.size() != n) begin failures++; $display("FAIL rstmid_no_pulse got=%0d exp=0", obs_q.size() - n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fifo_full();
        test_random(12);
        test_random(12);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_multi_src_sender.md
Name: uart_multi_src_sender

Overview:
Parametrised successor to the single-byte switch/keyboard UART sender. It accepts byte-wide send requests from NUM_SRC independent producers, such as switches+button, PS/2 ASCII path, and future sources. Each producer gets a one-entry holding register; a round-robin arbiter drains these into a shared TX FIFO. A handshake FSM feeds the existing uart transmitter with one start pulse per byte and obeys tx_busy. It sits between the source logic and the uart instance, and exports last-sent data for the seven-segment display.

Parameters:
NUM_SRC, 2, number of request sources (1..8)
DATA_W, 8, byte width per request and UART payload
FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2
TIMEOUT_CYC, 1024, cycles to wait for tx_busy to rise (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
src_valid  in  NUM_SRC  one-cycle request strobe per source
src_data  in  NUM_SRC*DATA_W  source i data in bits [i*DATA_W +: DATA_W]
src_drop  out  NUM_SRC  sticky: a request from source i was lost
clear_drop  in  1  clears all src_drop bits
tx_data  out  DATA_W  byte presented to uart
tx_start  out  1  one-cycle send pulse to uart
tx_busy  in  1  uart transmitter busy
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
last_sent  out  DATA_W  last byte issued on tx_start
last_src  out  max(1,$clog2(NUM_SRC))  source index of last_sent

Behaviour:
- Reset: all pending flags 0; FIFO empty; fifo_count=0; RR pointer=0; FSM=IDLE; tx_start=0; tx_data=0; last_sent=0; last_src=0; src_drop=0. Reset mid-transfer discards pending and FIFO contents without issuing a pulse.
- Holding register i loads src_data on src_valid[i] if it is empty, or if it is being granted in the same cycle.
- Otherwise the request is dropped and src_drop[i] is set. If clear_drop and a new drop occur in the same cycle, the set wins.
- Arbiter: each cycle it grants at most one pending source. The search starts at the index after the last grant and wraps at NUM_SRC.
- A grant happens only if FIFO not full, or a pop occurs in the same cycle. Each entry stores {src index, data}.
- FIFO: simultaneous push and pop at any occupancy leaves count unchanged. Read and write pointers wrap at FIFO_DEPTH. Never overflows or underflows.
- FSM states:
  - IDLE: if FIFO non-empty and !tx_busy, pop the entry, register tx_data/last_sent/last_src, pulse tx_start for exactly 1 cycle, go to WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for tx_busy=0, then go to IDLE.
- Latency when everything is idle: src_valid sampled at edge k; pending at k; FIFO write at k+1; tx_start registered at k+2, so it is high during the cycle after edge k+2. Minimum spacing between tx_start pulses is the uart frame time plus 2 cycles.
- tx_data holds its value until the next tx_start.
- Ordering is FIFO order. Per-source order is always preserved.

Optional Feature:
UART_SEND_TIMEOUT_EN:
- Defined: if tx_busy has not risen within TIMEOUT_CYC cycles in WAIT_HI, the FSM returns to IDLE and the byte is considered lost. A sticky output tx_timeout (1 bit, cleared by clear_drop) is added.
- Undefined: WAIT_HI waits indefinitely, there is no tx_timeout port, and no counter logic is synthesised.

Decomposition:
- Package uart_send_pkg holds: FSM state enum (IDLE, WAIT_HI, WAIT_LO), the FIFO entry struct typedef {src, data}, and the SRC_W/CNT_W width helper functions.
- One sub-module, sync_fifo (parametrised DATA_W+SRC_W, FIFO_DEPTH, with count output), is reused elsewhere in the codebase.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single request: src_valid[1] with 0x41, uart model raises busy 1 cycle after start for 100 cycles -> one tx_start 3 cycles after the valid; tx_data=0x41, last_src=1, src_drop=0.
- Simultaneous: both sources valid in the same cycle, data 0x11 and 0x22, RR pointer at 0 -> FIFO order 0x22 (src1) then 0x11 (src0); two tx_starts, neither before busy falls.
- Back-to-back on one source: src0 valid on 2 consecutive cycles with FIFO full -> second request dropped, src_drop[0]=1; clear_drop clears it.
- FIFO full: 17 requests with DEPTH=16 while tx_busy is held high -> fifo_count saturates at 16 plus 1 pending, then further drops. Releasing busy drains all 17 in order.
- Reset mid-transfer: assert rst while in WAIT_LO with 5 queued -> next cycle fifo_count=0, tx_start=0, no further pulses.
- With UART_SEND_TIMEOUT_EN and TIMEOUT_CYC=8, tx_busy stuck low -> tx_timeout=1 nine cycles after tx_start; next byte is issued.
